// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared mode type, default 640x480@60 timing and counter width helper
package vga_pkg;

  typedef enum logic {
    MODE_FILL = 1'b0,
    MODE_BOX  = 1'b1
  } mode_e;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  // Bits needed for a counter running 0..total-1, never narrower than one bit.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_driver_param_if.sv
// rtl/vga_driver_param_if.sv - VGA pixel/sync output bundle
interface vga_driver_param_if #(
  parameter int COLOR_BITS = 4
) ();
  logic [COLOR_BITS-1:0] VGA_R;
  logic [COLOR_BITS-1:0] VGA_G;
  logic [COLOR_BITS-1:0] VGA_B;
  logic                  VGA_HS;
  logic                  VGA_VS;
  logic                  frame_start;

  modport master (output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_start);
  modport slave  (input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel tick divider, scan counters and sync/visible/frame-end decode
module vga_timing_gen import vga_pkg::*; #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = DEF_H_VIS,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_VIS   = DEF_V_VIS,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BP    = DEF_V_BP,
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP,
  localparam int HW      = cnt_width(H_TOTAL),
  localparam int VW      = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          o_tick,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_hs_act,
  output logic          o_vs_act,
  output logic          o_visible,
  output logic          o_frame_end
);

  localparam int DW = cnt_width(CLK_DIV);

  logic [DW-1:0] r_div;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_tick;
  logic          w_h_last;
  logic          w_v_last;

  assign w_tick   = (r_div == DW'(CLK_DIV - 1));
  assign w_h_last = (r_h_cnt == HW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign o_tick      = w_tick;
  assign o_h_cnt     = r_h_cnt;
  assign o_v_cnt     = r_v_cnt;
  assign o_hs_act    = (int'(r_h_cnt) >= H_VIS + H_FP) && (int'(r_h_cnt) < H_VIS + H_FP + H_SYNC);
  assign o_vs_act    = (int'(r_v_cnt) >= V_VIS + V_FP) && (int'(r_v_cnt) < V_VIS + V_FP + V_SYNC);
  assign o_visible   = (int'(r_h_cnt) < H_VIS) && (int'(r_v_cnt) < V_VIS);
  assign o_frame_end = w_tick && w_h_last && w_v_last;

endmodule

// File: rtl/vga_driver_param.sv
// rtl/vga_driver_param.sv - VGA driver: button conditioning, pending/displayed state, pixel output
module vga_driver_param import vga_pkg::*; #(
  parameter int CLK_DIV    = 2,
  parameter int H_VIS      = DEF_H_VIS,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_VIS      = DEF_V_VIS,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int COLOR_BITS = 4,
  parameter int BOX_SIZE   = 32,
  parameter int STEP       = 8
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  change_button,
  input  logic                  set,
  input  logic [COLOR_BITS-1:0] R,
  input  logic [COLOR_BITS-1:0] G,
  input  logic [COLOR_BITS-1:0] B,
  input  logic                  East,
  input  logic                  West,
  input  logic                  North,
  input  logic                  South,
  vga_driver_param_if.master    vga
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  localparam int XW      = cnt_width(H_VIS);
  localparam int YW      = cnt_width(V_VIS);
  localparam int CW      = 3 * COLOR_BITS;

  localparam logic [XW:0] X_MAX  = (XW+1)'(H_VIS - BOX_SIZE);
  localparam logic [XW:0] X_STEP = (XW+1)'(STEP);
  localparam logic [YW:0] Y_MAX  = (YW+1)'(V_VIS - BOX_SIZE);
  localparam logic [YW:0] Y_STEP = (YW+1)'(STEP);

  localparam int B_CHG = 5, B_SET = 4, B_E = 3, B_W = 2, B_N = 1, B_S = 0;

  logic          w_tick, w_hs_act, w_vs_act, w_visible, w_frame_end;
  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS   (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk         (sysclk),
    .rst         (rst),
    .o_tick      (w_tick),
    .o_h_cnt     (w_h_cnt),
    .o_v_cnt     (w_v_cnt),
    .o_hs_act    (w_hs_act),
    .o_vs_act    (w_vs_act),
    .o_visible   (w_visible),
    .o_frame_end (w_frame_end)
  );

  logic [5:0] w_btn, r_sync1, r_sync2, r_prev, w_rise;

  assign w_btn  = {change_button, set, East, West, North, South};
  assign w_rise = r_sync2 & ~r_prev;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  mode_e         r_pmode, r_dmode;
  logic [CW-1:0] r_pcol, r_dcol;
  logic [XW-1:0] r_px, r_dx, w_x_next;
  logic [YW-1:0] r_py, r_dy, w_y_next;
  logic [XW:0]   w_x_ext, w_x_up, w_x_dn;
  logic [YW:0]   w_y_ext, w_y_up, w_y_dn;

  // One guard bit on each side so saturation is decided before anything can wrap.
  assign w_x_ext = {1'b0, r_px};
  assign w_x_up  = w_x_ext + X_STEP;
  assign w_x_dn  = w_x_ext - X_STEP;
  assign w_y_ext = {1'b0, r_py};
  assign w_y_up  = w_y_ext + Y_STEP;
  assign w_y_dn  = w_y_ext - Y_STEP;

  always_comb begin
    w_x_next = r_px;
    if (w_rise[B_E] && !w_rise[B_W])
      w_x_next = (w_x_up > X_MAX) ? X_MAX[XW-1:0] : w_x_up[XW-1:0];
    else if (w_rise[B_W] && !w_rise[B_E])
      w_x_next = (w_x_ext < X_STEP) ? '0 : w_x_dn[XW-1:0];
  end

  always_comb begin
    w_y_next = r_py;
    if (w_rise[B_S] && !w_rise[B_N])
      w_y_next = (w_y_up > Y_MAX) ? Y_MAX[YW-1:0] : w_y_up[YW-1:0];
    else if (w_rise[B_N] && !w_rise[B_S])
      w_y_next = (w_y_ext < Y_STEP) ? '0 : w_y_dn[YW-1:0];
  end

  // Displayed state loads from the pre-edge pending values, so a press on the commit edge waits a frame.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_pmode <= MODE_FILL;
      r_pcol  <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_dmode <= MODE_FILL;
      r_dcol  <= '0;
      r_dx    <= '0;
      r_dy    <= '0;
    end else begin
      if (w_rise[B_CHG])
        r_pmode <= (r_pmode == MODE_FILL) ? MODE_BOX : MODE_FILL;
      if (w_rise[B_SET])
        r_pcol <= {R, G, B};
      r_px <= w_x_next;
      r_py <= w_y_next;
      if (w_frame_end) begin
        r_dmode <= r_pmode;
        r_dcol  <= r_pcol;
        r_dx    <= r_px;
        r_dy    <= r_py;
      end
    end
  end

  logic          w_in_box;
  logic [CW-1:0] w_pix;

  assign w_in_box = (int'(w_h_cnt) >= int'(r_dx)) && (int'(w_h_cnt) < int'(r_dx) + BOX_SIZE) &&
                    (int'(w_v_cnt) >= int'(r_dy)) && (int'(w_v_cnt) < int'(r_dy) + BOX_SIZE);
  assign w_pix    = (w_visible && (r_dmode == MODE_FILL || w_in_box)) ? r_dcol : '0;

  logic [COLOR_BITS-1:0] r_vga_r, r_vga_g, r_vga_b;
  logic                  r_vga_hs, r_vga_vs, r_frame_start;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_vga_r       <= '0;
      r_vga_g       <= '0;
      r_vga_b       <= '0;
      r_vga_hs      <= ~SYNC_POL;
      r_vga_vs      <= ~SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_end;
      if (w_tick) begin
        {r_vga_r, r_vga_g, r_vga_b} <= w_pix;
        r_vga_hs <= w_hs_act ? SYNC_POL : ~SYNC_POL;
        r_vga_vs <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign vga.VGA_R       = r_vga_r;
  assign vga.VGA_G       = r_vga_g;
  assign vga.VGA_B       = r_vga_b;
  assign vga.VGA_HS      = r_vga_hs;
  assign vga.VGA_VS      = r_vga_vs;
  assign vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_driver_param.sv
// tb/tb_vga_driver_param.sv - directed bench: default-width timing (dut_a) and small-raster box logic (dut_b)
module tb_vga_driver_param;

  localparam int HT_B = 24;
  localparam logic [5:0] P_CHG = 6'b100000, P_SET = 6'b010000, P_E = 6'b001000,
                         P_W   = 6'b000100, P_N   = 6'b000010, P_S = 6'b000001;
  localparam int COL = 'hF0A;

  logic       sysclk = 1'b0;
  logic       rst_a  = 1'b1;
  logic       rst_b  = 1'b1;
  logic       zero1  = 1'b0;
  logic [3:0] zero4  = 4'h0;
  logic       b_chg = 0, b_set = 0, b_e = 0, b_w = 0, b_n = 0, b_s = 0;
  logic [3:0] b_r = 0, b_g = 0, b_b = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fs_cyc  = 0;
  bit a_rgb_bad = 0;

  vga_driver_param_if #(.COLOR_BITS(4)) a_if ();
  vga_driver_param_if #(.COLOR_BITS(4)) b_if ();

  vga_driver_param #(
    .CLK_DIV(2), .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .BOX_SIZE(2), .STEP(1)
  ) dut_a (
    .sysclk(sysclk), .rst(rst_a), .change_button(zero1), .set(zero1),
    .R(zero4), .G(zero4), .B(zero4),
    .East(zero1), .West(zero1), .North(zero1), .South(zero1), .vga(a_if)
  );

  vga_driver_param #(
    .CLK_DIV(2), .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b0), .COLOR_BITS(4), .BOX_SIZE(4), .STEP(2)
  ) dut_b (
    .sysclk(sysclk), .rst(rst_b), .change_button(b_chg), .set(b_set),
    .R(b_r), .G(b_g), .B(b_b),
    .East(b_e), .West(b_w), .North(b_n), .South(b_s), .vga(b_if)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;
  always @(negedge sysclk)
    if (!rst_a && ({a_if.VGA_R, a_if.VGA_G, a_if.VGA_B} != 12'h000)) a_rgb_bad <= 1'b1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int b_rgb();
    return int'({b_if.VGA_R, b_if.VGA_G, b_if.VGA_B});
  endfunction

  task automatic press(input logic [5:0] m);
    @(negedge sysclk);
    {b_chg, b_set, b_e, b_w, b_n, b_s} = m;
    repeat (4) @(negedge sysclk);
    {b_chg, b_set, b_e, b_w, b_n, b_s} = 6'b0;
    repeat (4) @(negedge sysclk);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!b_if.frame_start && n < 2000);
    check("b_frame_start", int'(b_if.frame_start), 1);
    fs_cyc = cyc;
  endtask

  // Pixel (h,v) is on the outputs from edge fs_cyc + 2*(1 + v*HT_B + h) for two cycles.
  task automatic sample_cur(input string tag, input int h, input int v, input int exp);
    int target;
    target = fs_cyc + 2 * (1 + v * HT_B + h);
    if (cyc > target) check({tag, "_late"}, cyc, target);
    while (cyc < target) @(negedge sysclk);
    check(tag, b_rgb(), exp);
  endtask

  task automatic check_pix(input string tag, input int h, input int v, input int exp);
    wait_fs();
    sample_cur(tag, h, v, exp);
  endtask

  task automatic measure(input int sel, output int period, output int low_w);
    int t_f1, t_r, t_f2;
    logic prev, cur;
    t_f1 = -1; t_r = -1; t_f2 = -1;
    prev = sel ? a_if.VGA_VS : a_if.VGA_HS;
    for (int n = 0; n < 30000 && t_f2 < 0; n++) begin
      @(negedge sysclk);
      cur = sel ? a_if.VGA_VS : a_if.VGA_HS;
      if (prev && !cur) begin
        if (t_f1 < 0) t_f1 = cyc;
        else t_f2 = cyc;
      end
      if (!prev && cur && t_f1 >= 0 && t_r < 0) t_r = cyc;
      prev = cur;
    end
    period = (t_f2 >= 0) ? t_f2 - t_f1 : -1;
    low_w  = (t_r >= 0) ? t_r - t_f1 : -1;
  endtask

  initial begin
    int p, l, n, bad;
    repeat (3) @(negedge sysclk);
    check("rst_a_hs", int'(a_if.VGA_HS), 1);
    check("rst_a_vs", int'(a_if.VGA_VS), 1);
    check("rst_a_rgb", int'({a_if.VGA_R, a_if.VGA_G, a_if.VGA_B}), 0);
    check("rst_a_fs", int'(a_if.frame_start), 0);
    check("rst_b_hs", int'(b_if.VGA_HS), 1);
    check("rst_b_rgb", b_rgb(), 0);

    // Default horizontal timing, shortened vertical.
    rst_a = 1'b0;
    measure(0, p, l);
    check("a_hs_period", p, 1600);
    check("a_hs_low", l, 192);
    measure(1, p, l);
    check("a_vs_period", p, 11200);
    check("a_vs_low", l, 1600);
    check("a_rgb_zero", int'(a_rgb_bad), 0);

    // Asynchronous reset while HS is active.
    n = 0;
    while (a_if.VGA_HS !== 1'b0 && n < 4000) begin
      @(negedge sysclk);
      n++;
    end
    check("a_hs_active_before_rst", int'(a_if.VGA_HS), 0);
    rst_a = 1'b1;
    #1;
    check("a_midrst_hs", int'(a_if.VGA_HS), 1);
    check("a_midrst_vs", int'(a_if.VGA_VS), 1);
    check("a_midrst_rgb", int'({a_if.VGA_R, a_if.VGA_G, a_if.VGA_B}), 0);
    repeat (3) @(negedge sysclk);
    rst_a = 1'b0;
    n = 0;
    while (n < 3000) begin
      @(posedge sysclk);
      #1;
      n++;
      if (a_if.VGA_HS == 1'b0) break;
    end
    check("a_first_hs_fall_cycles", n, 1314);

    // Colour latch commits only at the frame boundary.
    @(negedge sysclk);
    rst_b = 1'b0;
    b_r = 4'hF; b_g = 4'h0; b_b = 4'hA;
    press(P_SET);
    bad = 0;
    for (n = 0; n < 2000; n++) begin
      @(negedge sysclk);
      if (b_if.frame_start) break;
      if (b_rgb() != 0) bad = 1;
    end
    check("b_frame_start_first", int'(b_if.frame_start), 1);
    fs_cyc = cyc;
    check("b_rgb_zero_before_commit", bad, 0);
    sample_cur("b_fill_3_2", 3, 2, COL);
    sample_cur("b_hblank_16_2", 16, 2, 0);
    sample_cur("b_vblank_3_12", 3, 12, 0);

    // Box mode, West saturation at 0.
    wait_fs();
    press(P_CHG);
    press(P_W);
    check_pix("b_box_0_0", 0, 0, COL);
    sample_cur("b_box_3_0", 3, 0, COL);
    sample_cur("b_box_4_0", 4, 0, 0);

    press(P_E); press(P_E); press(P_E);
    check_pix("b_x6_5_0", 5, 0, 0);
    sample_cur("b_x6_6_0", 6, 0, COL);
    sample_cur("b_x6_9_3", 9, 3, COL);
    sample_cur("b_x6_10_3", 10, 3, 0);
    sample_cur("b_x6_6_4", 6, 4, 0);

    press(P_E | P_W);
    check_pix("b_ew_5_0", 5, 0, 0);
    sample_cur("b_ew_6_0", 6, 0, COL);
    sample_cur("b_ew_10_0", 10, 0, 0);

    for (int i = 0; i < 10; i++) press(P_E);
    check_pix("b_xsat_11_0", 11, 0, 0);
    sample_cur("b_xsat_12_0", 12, 0, COL);
    sample_cur("b_xsat_15_0", 15, 0, COL);

    // Vertical: y=4, then a mid-frame North, then a North on the commit edge.
    press(P_S); press(P_S);
    check_pix("b_y4_12_3", 12, 3, 0);
    sample_cur("b_y4_12_4", 12, 4, COL);
    press(P_N);
    sample_cur("b_y4_held_12_7", 12, 7, COL);
    check_pix("b_y2_12_1", 12, 1, 0);
    sample_cur("b_y2_12_2", 12, 2, COL);
    sample_cur("b_y2_12_6", 12, 6, 0);

    while (cyc < fs_cyc + 765) @(negedge sysclk);
    b_n = 1'b1;
    repeat (2) @(negedge sysclk);
    b_n = 1'b0;
    check_pix("b_coinc_held_12_1", 12, 1, 0);
    sample_cur("b_coinc_held_12_2", 12, 2, COL);
    check_pix("b_coinc_y0_12_0", 12, 0, COL);
    sample_cur("b_coinc_y0_12_4", 12, 4, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_driver_param.md
Name: vga_driver_param

Overview:
Parametrised successor to the fixed 640x480 vgadriver. It generates VGA sync and pixel colour with configurable timing, pixel clock divide, colour depth and sync polarity. Two display modes are selected by change_button: solid fill, or a movable box steered by the direction buttons. All user-visible state changes are committed only at frame boundaries, so there is no tearing.

Parameters:
CLK_DIV, 2, sysclk cycles per pixel tick (>=1); 50 MHz / 2 = 25 MHz pixel rate
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VIS, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active sync level (0 = active-low)
COLOR_BITS, 4, bits per colour channel
BOX_SIZE, 32, box edge length in pixels (< H_VIS, < V_VIS)
STEP, 8, pixels moved per direction press

Ports:
sysclk  in  1  system clock
rst  in  1  asynchronous reset, active-high
change_button  in  1  mode toggle, async button
set  in  1  latch R/G/B into the pending colour, async button
R  in  COLOR_BITS  red value to latch
G  in  COLOR_BITS  green value to latch
B  in  COLOR_BITS  blue value to latch
East  in  1  move box +x
West  in  1  move box -x
North  in  1  move box -y
South  in  1  move box +y
VGA_R  out  COLOR_BITS  red pixel
VGA_G  out  COLOR_BITS  green pixel
VGA_B  out  COLOR_BITS  blue pixel
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
frame_start  out  1  one-sysclk pulse on the commit tick

Behaviour:
- Clock and reset: one clock, sysclk. rst is asynchronous and active-high; every flop clears immediately on assertion.
- Reset values:
  - Counters 0; mode 0.
  - Pending and displayed colour 0; pending and displayed box position (0,0).
  - VGA_R/G/B = 0; VGA_HS = VGA_VS = ~SYNC_POL; frame_start = 0.
- Pixel tick: a div counter runs 0..CLK_DIV-1. tick = 1 in the cycle where the counter equals CLK_DIV-1; then it wraps to 0.
- Scan counters (advance on tick only):
  - H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP; V_TOTAL defined likewise.
  - h_cnt wraps at H_TOTAL-1. v_cnt increments on h_cnt wrap and itself wraps at V_TOTAL-1.
- Sync: HS is active while H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC. VS uses the same rule on v_cnt.
- Outputs: all registered and updated on tick. They show the state of the counters before the tick, i.e. one pixel of latency, identical for sync and colour.
- Input conditioning: every button input passes through a 2-flop synchroniser and a rising-edge detector. Each press gives exactly one action. R/G/B are sampled from the synchronised set edge cycle.
- Pending state (updates immediately):
  - change_button edge: toggle pending_mode.
  - set edge: pending_colour <= {R,G,B}.
  - East edge: x += STEP, saturating at H_VIS-BOX_SIZE. West edge: x -= STEP, saturating at 0.
  - South edge: y += STEP, saturating at V_VIS-BOX_SIZE. North edge: y -= STEP, saturating at 0.
  - East and West in the same cycle: x unchanged. North and South in the same cycle: y unchanged.
  - Width rule: compute with one extra bit so saturation never wraps.
- Commit: on the tick where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, the displayed mode, colour and position load from pending. frame_start pulses in that cycle.
  - Any press in the same cycle as the commit lands in pending and shows one frame later.
- Colour selection:
  - Outside the visible area: 0.
  - Mode 0: visible pixels = displayed colour.
  - Mode 1: displayed colour where x <= h_cnt < x+BOX_SIZE and y <= v_cnt < y+BOX_SIZE; otherwise 0.
- Reset mid-frame: outputs drop to reset values at once. Scanning restarts at (0,0) on the first tick after release.

Decomposition:
- Package vga_pkg: the mode enum (MODE_FILL=0, MODE_BOX=1), the default 640x480@60 timing constants, and a function that computes counter widths from totals (clog2).
- Sub-module vga_timing_gen holds the div counter, h/v counters, tick, sync decode, visible flag and the frame-end flag.
- Button conditioning and pending/displayed state stay in the top level.

Test Plan:
1. Defaults, reset released, run 2 frames -> HS period 1600 sysclk, HS low 192 sysclk. VS period 840000 sysclk, VS low 3200 sysclk. RGB = 0 throughout.
2. R=F, G=0, B=A, then one set pulse -> RGB stays 0 until the next frame_start. After it, visible pixels read F/0/A; pixels with h_cnt>=640 read 0.
3. Small timing (H_VIS=16, V_VIS=12, BOX_SIZE=4, STEP=2): toggle to mode 1, then 3 East pulses -> after commit, box at x=6. Pixel (6,0) is coloured, pixel (5,0) is black.
4. Saturation: West at x=0 -> x stays 0. Ten East pulses -> x = H_VIS-BOX_SIZE (12 in the small config). East+West in the same cycle -> x unchanged.
5. North pulse mid-frame at y=4 -> displayed y stays 4 until frame_start, then becomes 2. A press coincident with frame_start shows one frame later.
6. rst asserted mid-line -> same sysclk edge: HS/VS inactive (1), RGB 0, counters 0. After release, the first HS falling edge is at 656 ticks.
